// File: rtl/pipe_intr_cp0_pkg.sv
// pipe_intr_cp0_pkg: CP0 register numbers, exception codes, PC-select encodings and interrupt FSM states
package pipe_intr_cp0_pkg;
  localparam logic [4:0] C0_STATUS = 5'd12;
  localparam logic [4:0] C0_CAUSE = 5'd13;
  localparam logic [4:0] C0_EPC = 5'd14;
  localparam logic [4:0] EXC_OV = 5'd12;
  localparam logic [4:0] EXC_UNIMPL = 5'd10;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [1:0] SEL_NPC = 2'b00;
  localparam logic [1:0] SEL_EPC = 2'b01;
  localparam logic [1:0] SEL_EXC = 2'b10;
  localparam logic [31:0] EXC_BASE = 32'h0000_0008;
  localparam logic [31:0] CAUSE_MASK = 32'h8000_007C;
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} int_state_t;
endpackage

// File: rtl/pipe_intr_cp0_ctrl_mux4x32.sv
// mux4x32: 4-input 32-bit multiplexer
module mux4x32 (
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [1:0]  s,
  output logic [31:0] y
);
  always_comb y = s[1] ? (s[0] ? a3 : a2) : (s[0] ? a1 : a0);
endmodule

// File: rtl/pipe_intr_cp0_ctrl.sv
// pipe_intr_cp0_ctrl: CP0 exception/interrupt control for a pipelined CPU
module pipe_intr_cp0_ctrl
  import pipe_intr_cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        intr,
  output logic        inta,
  input  logic [31:0] id_pc,
  input  logic        id_bd,
  input  logic        id_syscall,
  input  logic        id_unimpl,
  input  logic        id_eret,
  input  logic        id_stall,
  input  logic [31:0] exe_pc,
  input  logic        exe_ov,
  input  logic        exe_bd,
  input  logic        mtc0,
  input  logic [4:0]  c0_rd,
  input  logic [31:0] c0_wdata,
  output logic [31:0] c0_rdata,
  output logic [1:0]  selpc,
  output logic [31:0] epc,
  output logic        cancel,
  output logic [31:0] status,
  output logic [31:0] cause
);
  int_state_t state, state_n;
  logic ov, un, sc, it, exc, eret_ok, int_take, bd;
  logic [4:0] code;
  logic [31:0] epc_n;
  logic [1:0] rd_sel;
  always_comb begin
    ov = exe_ov & status[3];
    un = id_unimpl & status[2] & ~id_stall;
    sc = id_syscall & status[1] & ~id_stall;
    it = intr & status[0] & ~id_stall & (state == S_IDLE);
    exc = ov | un | sc | it;
    int_take = it & ~ov & ~un & ~sc;
    eret_ok = id_eret & ~id_stall & ~exc;
    code = ov ? EXC_OV : un ? EXC_UNIMPL : sc ? EXC_SYSCALL : EXC_INT;
    bd = ov ? exe_bd : id_bd;
    // EPC points at the branch when the faulting instruction sits in its delay slot
    epc_n = ov ? (exe_bd ? exe_pc - 32'd4 : exe_pc) : (id_bd ? id_pc - 32'd4 : id_pc);
    selpc = rst ? SEL_NPC : exc ? SEL_EXC : eret_ok ? SEL_EPC : SEL_NPC;
    cancel = exc & ~rst;
    state_n = state == S_IDLE ? (int_take ? S_ACK : S_IDLE) : (intr ? S_WAIT : S_IDLE);
    rd_sel = c0_rd == C0_STATUS ? 2'd0 : c0_rd == C0_CAUSE ? 2'd1 : c0_rd == C0_EPC ? 2'd2 : 2'd3;
  end
  assign inta = state == S_ACK;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      status <= '0;
      cause <= '0;
      epc <= '0;
    end else begin
      state <= state_n;
      status <= exc ? status << 4 : eret_ok ? status >> 4 : (mtc0 && c0_rd == C0_STATUS) ? c0_wdata : status;
      cause <= exc ? {bd, 24'b0, code, 2'b0} : (mtc0 && c0_rd == C0_CAUSE) ? c0_wdata & CAUSE_MASK : cause;
      epc <= exc ? epc_n : (mtc0 && c0_rd == C0_EPC) ? c0_wdata : epc;
    end
  end
  mux4x32 u_rd_mux (.a0(status), .a1(cause), .a2(epc), .a3(32'b0), .s(rd_sel), .y(c0_rdata));
endmodule

// File: tb/tb_pipe_intr_cp0_ctrl.sv
// tb_pipe_intr_cp0_ctrl: scoreboard bench for the CP0 exception/interrupt controller
module tb_pipe_intr_cp0_ctrl;
  logic clk = 0, rst, intr, inta, id_bd, id_syscall, id_unimpl, id_eret, id_stall;
  logic exe_ov, exe_bd, mtc0, cancel;
  logic [31:0] id_pc, exe_pc, c0_wdata, c0_rdata, epc, status, cause;
  logic [4:0] c0_rd;
  logic [1:0] selpc;
  logic [99:0] q[$], e;
  logic [31:0] rq[$], re;
  int vecs = 0, errs = 0;
  wire [99:0] obs = {selpc, cancel, inta, status, cause, epc};

  pipe_intr_cp0_ctrl dut (.clk(clk), .rst(rst), .intr(intr), .inta(inta), .id_pc(id_pc), .id_bd(id_bd),
    .id_syscall(id_syscall), .id_unimpl(id_unimpl), .id_eret(id_eret), .id_stall(id_stall),
    .exe_pc(exe_pc), .exe_ov(exe_ov), .exe_bd(exe_bd), .mtc0(mtc0), .c0_rd(c0_rd), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .selpc(selpc), .epc(epc), .cancel(cancel), .status(status), .cause(cause));

  always #5 clk = ~clk;

  function automatic logic [99:0] mk(input logic [1:0] s, input logic c, input logic a,
                                     input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
    return {s, c, a, st, ca, ep};
  endfunction

  task automatic clr();
    rst = 0; intr = 0; id_pc = 0; id_bd = 0; id_syscall = 0; id_unimpl = 0; id_eret = 0; id_stall = 0;
    exe_pc = 0; exe_ov = 0; exe_bd = 0; mtc0 = 0; c0_rd = 0; c0_wdata = 0;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    mtc0 = 1; c0_rd = rd; c0_wdata = d;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      clr();
      case (i)
        0: begin rst = 1; exe_ov = 1; intr = 1; end
        1: begin rst = 1; wr(12, 32'hF); end
        default: ;
      endcase
      q.push_back(mk(2'b00, 0, 0, 0, 0, 0));
      @(negedge clk); e = q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL reset[%0d] got %h exp %h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_intr();
    for (int i = 0; i < 4; i++) begin
      clr();
      case (i)
        0: begin wr(12, 32'h1); q.push_back(mk(2'b00, 0, 0, 0, 0, 0)); end
        1: begin intr = 1; id_pc = 32'h100; q.push_back(mk(2'b10, 1, 0, 32'h1, 0, 0)); end
        2: begin intr = 1; q.push_back(mk(2'b00, 0, 1, 32'h10, 0, 32'h100)); end
        default: q.push_back(mk(2'b00, 0, 0, 32'h10, 0, 32'h100));
      endcase
      @(negedge clk); e = q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL intr[%0d] got %h exp %h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 3; i++) begin
      clr();
      case (i)
        0: begin wr(12, 32'hF); q.push_back(mk(2'b00, 0, 0, 32'h10, 0, 32'h100)); end
        1: begin
          exe_ov = 1; exe_pc = 32'h204; exe_bd = 1; id_syscall = 1; id_pc = 32'h300;
          q.push_back(mk(2'b10, 1, 0, 32'hF, 0, 32'h100));
        end
        default: q.push_back(mk(2'b00, 0, 0, 32'hF0, 32'h8000_0030, 32'h200));
      endcase
      @(negedge clk); e = q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL priority[%0d] got %h exp %h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_eret();
    for (int i = 0; i < 5; i++) begin
      clr();
      case (i)
        0: begin wr(12, 32'h10); q.push_back(mk(2'b00, 0, 0, 32'hF0, 32'h8000_0030, 32'h200)); end
        1: begin id_eret = 1; wr(12, 32'hFF); q.push_back(mk(2'b01, 0, 0, 32'h10, 32'h8000_0030, 32'h200)); end
        3: begin id_eret = 1; id_stall = 1; q.push_back(mk(2'b00, 0, 0, 32'h1, 32'h8000_0030, 32'h200)); end
        default: q.push_back(mk(2'b00, 0, 0, 32'h1, 32'h8000_0030, 32'h200));
      endcase
      @(negedge clk); e = q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL eret[%0d] got %h exp %h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_intr_wait();
    for (int i = 0; i < 10; i++) begin
      clr();
      case (i)
        0: begin intr = 1; id_pc = 32'h40; q.push_back(mk(2'b10, 1, 0, 32'h1, 32'h8000_0030, 32'h200)); end
        1: begin intr = 1; wr(12, 32'h1); q.push_back(mk(2'b00, 0, 1, 32'h10, 0, 32'h40)); end
        2, 3, 4, 5: begin intr = 1; q.push_back(mk(2'b00, 0, 0, 32'h1, 0, 32'h40)); end
        6: q.push_back(mk(2'b00, 0, 0, 32'h1, 0, 32'h40));
        7: begin intr = 1; id_pc = 32'h80; q.push_back(mk(2'b10, 1, 0, 32'h1, 0, 32'h40)); end
        8: q.push_back(mk(2'b00, 0, 1, 32'h10, 0, 32'h80));
        default: q.push_back(mk(2'b00, 0, 0, 32'h10, 0, 32'h80));
      endcase
      @(negedge clk); e = q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL intr_wait[%0d] got %h exp %h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      clr();
      case (i)
        0: begin wr(12, 32'h4); q.push_back(mk(2'b00, 0, 0, 32'h10, 0, 32'h80)); end
        1, 2: begin id_stall = 1; id_unimpl = 1; id_pc = 32'h500; id_bd = 1; q.push_back(mk(2'b00, 0, 0, 32'h4, 0, 32'h80)); end
        3: begin id_unimpl = 1; id_pc = 32'h500; id_bd = 1; q.push_back(mk(2'b10, 1, 0, 32'h4, 0, 32'h80)); end
        default: q.push_back(mk(2'b00, 0, 0, 32'h40, 32'h8000_0028, 32'h4FC));
      endcase
      @(negedge clk); e = q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL stall[%0d] got %h exp %h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mtc0();
    logic [4:0] rds [5] = '{5'd12, 5'd13, 5'd14, 5'd7, 5'd0};
    logic [31:0] rv [5] = '{32'h20, 32'h8000_0020, 32'h1234, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      clr();
      case (i)
        0: begin wr(13, 32'hFFFF_FFFF); q.push_back(mk(2'b00, 0, 0, 32'h40, 32'h8000_0028, 32'h4FC)); end
        1: begin wr(12, 32'h2); q.push_back(mk(2'b00, 0, 0, 32'h40, 32'h8000_007C, 32'h4FC)); end
        2: begin id_syscall = 1; id_pc = 0; id_bd = 1; wr(14, 32'h1234); q.push_back(mk(2'b10, 1, 0, 32'h2, 32'h8000_007C, 32'h4FC)); end
        3: begin id_syscall = 1; id_pc = 32'h8; q.push_back(mk(2'b00, 0, 0, 32'h20, 32'h8000_0020, 32'hFFFF_FFFC)); end
        4: begin wr(14, 32'h1234); q.push_back(mk(2'b00, 0, 0, 32'h20, 32'h8000_0020, 32'hFFFF_FFFC)); end
        default: q.push_back(mk(2'b00, 0, 0, 32'h20, 32'h8000_0020, 32'h1234));
      endcase
      @(negedge clk); e = q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL mtc0[%0d] got %h exp %h", i, obs, e); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      c0_rd = rds[i]; rq.push_back(rv[i]);
      #1; re = rq.pop_front(); vecs++;
      if (c0_rdata !== re) begin errs++; $display("FAIL rdata[%0d] got %h exp %h", rds[i], c0_rdata, re); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_ack();
    for (int i = 0; i < 7; i++) begin
      clr();
      case (i)
        0: begin wr(12, 32'h1); q.push_back(mk(2'b00, 0, 0, 32'h20, 32'h8000_0020, 32'h1234)); end
        1: begin intr = 1; id_pc = 32'h600; q.push_back(mk(2'b10, 1, 0, 32'h1, 32'h8000_0020, 32'h1234)); end
        2: begin intr = 1; rst = 1; q.push_back(mk(2'b00, 0, 1, 32'h10, 0, 32'h600)); end
        3: q.push_back(mk(2'b00, 0, 0, 0, 0, 0));
        4: begin wr(12, 32'h1); q.push_back(mk(2'b00, 0, 0, 0, 0, 0)); end
        5: begin intr = 1; id_pc = 32'h700; q.push_back(mk(2'b10, 1, 0, 32'h1, 0, 0)); end
        default: q.push_back(mk(2'b00, 0, 1, 32'h10, 0, 32'h700));
      endcase
      @(negedge clk); e = q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL reset_ack[%0d] got %h exp %h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clr(); rst = 1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_intr();
    test_priority();
    test_eret();
    test_intr_wait();
    test_stall();
    test_mtc0();
    test_reset_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
